// File: rtl/dense_seq_ctrl_if.sv
// Bus bundle for the dense-layer sequencer: layer handshake, memory read
// ports, sigmoid LUT lookup and result write port.
interface dense_seq_ctrl_if #(
  parameter int N_IN  = 1600,
  parameter int N_OUT = 10,
  parameter int IMG_W = 12,
  parameter int W_W   = 4,
  parameter int B_W   = 4
);
  localparam int X_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int J_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [J_W-1:0]    img_addr;
  logic [WA_W-1:0]   w_addr;
  logic [X_W-1:0]    b_addr;
  logic [IMG_W-1:0]  img_rdata;
  logic [W_W-1:0]    w_rdata;
  logic [B_W-1:0]    b_rdata;
  logic [7:0]        lut_idx;
  logic [15:0]       lut_data;
  logic              out_we;
  logic [X_W-1:0]    out_addr;
  logic [15:0]       out_data;

  modport master (
    input  start, stall, img_rdata, w_rdata, b_rdata, lut_data,
    output busy, done, rd_en, img_addr, w_addr, b_addr, lut_idx,
           out_we, out_addr, out_data
  );

  modport slave (
    output start, stall, img_rdata, w_rdata, b_rdata, lut_data,
    input  busy, done, rd_en, img_addr, w_addr, b_addr, lut_idx,
           out_we, out_addr, out_data
  );
endinterface

// File: rtl/dense_seq_ctrl.sv
// Dense output-layer sequencer: walks neuron x / input j, drives the image,
// weight and bias reads, runs one signed MAC and writes sigmoid(acc) per neuron.
module dense_seq_ctrl #(
  parameter int N_IN    = 1600,
  parameter int N_OUT   = 10,
  parameter int IMG_W   = 12,
  parameter int W_W     = 4,
  parameter int B_W     = 4,
  parameter int ACC_W   = 32,
  parameter int LUT_LSB = 24
) (
  input  logic              clock,
  input  logic              rst_n,
  dense_seq_ctrl_if.master  bus
);
  localparam int X_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int J_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int P_W  = IMG_W + W_W;

  localparam logic [X_W-1:0]  X_MAX  = X_W'(N_OUT - 1);
  localparam logic [J_W-1:0]  J_MAX  = J_W'(N_IN - 1);
  localparam logic [X_W-1:0]  X_ONE  = X_W'(1);
  localparam logic [J_W-1:0]  J_ONE  = J_W'(1);
  localparam logic [WA_W-1:0] WA_ONE = WA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_B = 3'd1,
    S_MAC     = 3'd2,
    S_DRAIN   = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [WA_W-1:0]   wa_q, wa_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              pend_q, pend_d;
  logic              busy_q, rd_en_q, out_we_q, done_q;

  logic signed [P_W-1:0] img_ext_s, w_ext_s, prod_s;
  logic [ACC_W-1:0]      prod_ext_s, bias_ext_s;

  // Full-width signed product, sign-extended into the accumulator domain.
  assign img_ext_s  = {{W_W{bus.img_rdata[IMG_W-1]}}, bus.img_rdata};
  assign w_ext_s    = {{IMG_W{bus.w_rdata[W_W-1]}}, bus.w_rdata};
  assign prod_s     = img_ext_s * w_ext_s;
  assign prod_ext_s = {{(ACC_W-P_W){prod_s[P_W-1]}}, prod_s};
  assign bias_ext_s = {{(ACC_W-B_W){bus.b_rdata[B_W-1]}}, bus.b_rdata};

  // Next-state, index and accumulator update; stall freezes everything except
  // remembering a start that arrives while idle.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    j_d     = j_q;
    wa_d    = wa_q;
    acc_d   = acc_q;
    pend_d  = pend_q;
    if (bus.stall) begin
      if ((state_q == S_IDLE) && bus.start) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start || pend_q) begin
            state_d = S_FETCH_B;
            x_d     = '0;
            j_d     = '0;
            wa_d    = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH_B: begin
          state_d = S_MAC;
          j_d     = '0;
        end
        S_MAC: begin
          if (j_q == '0) begin
            acc_d = bias_ext_s;
          end else begin
            acc_d = acc_q + prod_ext_s;
          end
          if (j_q == J_MAX) begin
            state_d = S_DRAIN;
          end else begin
            j_d  = j_q + J_ONE;
            wa_d = wa_q + WA_ONE;
          end
        end
        S_DRAIN: begin
          acc_d   = acc_q + prod_ext_s;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (x_q == X_MAX) begin
            state_d = S_DONE;
          end else begin
            // Weight row of neuron x+1 starts right after the last entry of row x.
            x_d     = x_q + X_ONE;
            j_d     = '0;
            wa_d    = wa_q + WA_ONE;
            state_d = S_FETCH_B;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      j_q      <= '0;
      wa_q     <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      out_we_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      j_q      <= j_d;
      wa_q     <= wa_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      busy_q   <= (state_d != S_IDLE);
      rd_en_q  <= (state_d == S_FETCH_B) || (state_d == S_MAC);
      out_we_q <= (state_d == S_WRITE);
      done_q   <= (state_d == S_DONE);
    end
  end

  // Strobes are suppressed during the stalled cycle itself.
  assign bus.busy     = busy_q;
  assign bus.rd_en    = rd_en_q & ~bus.stall;
  assign bus.out_we   = out_we_q & ~bus.stall;
  assign bus.done     = done_q & ~bus.stall;
  assign bus.img_addr = j_q;
  assign bus.w_addr   = wa_q;
  assign bus.b_addr   = x_q;
  assign bus.out_addr = x_q;
  assign bus.lut_idx  = acc_q[LUT_LSB +: 8];
  assign bus.out_data = bus.lut_data;
endmodule
